// File: rtl/chess_pkg.sv
// Shared definitions for the chess game: controller states and player encodings.
// The layout matrix imports the same player constants so both blocks agree on colour.
package chess_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_OVER   = 2'd3
   } state_e;

   localparam logic WHITE_PLAYER = 1'b1;
   localparam logic BLACK_PLAYER = 1'b0;

endpackage

// File: rtl/player_timer.sv
// One player's countdown clock: load to the initial time, tick down, and add a
// saturating per-move increment (applied after a same-cycle decrement).
module player_timer #(
   parameter int TIME_WIDTH        = 12,
   parameter int INIT_SECONDS      = 300,
   parameter int INCREMENT_SECONDS = 2
) (
   input  logic                  clock,
   input  logic                  resetApp,
   input  logic                  load,
   input  logic                  dec_en,
   input  logic                  inc_en,
   output logic [TIME_WIDTH-1:0] time_o,
   output logic                  will_zero_o
);

   localparam logic [TIME_WIDTH-1:0] INIT_VAL = TIME_WIDTH'(INIT_SECONDS);
   localparam logic [TIME_WIDTH-1:0] MAX_VAL  = '1;
   localparam logic [TIME_WIDTH:0]   INC_EXT  = (TIME_WIDTH + 1)'(INCREMENT_SECONDS);

   logic [TIME_WIDTH-1:0] time_q, time_d;
   logic [TIME_WIDTH-1:0] dec_val;
   logic [TIME_WIDTH-1:0] base_val;
   logic [TIME_WIDTH:0]   sum_ext;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      dec_val  = (time_q != '0) ? time_q - 1'b1 : time_q;
      base_val = dec_en ? dec_val : time_q;
      sum_ext  = {1'b0, base_val} + INC_EXT;
      time_d   = time_q;
      if (load)
         time_d = INIT_VAL;
      else if (inc_en)
         time_d = sum_ext[TIME_WIDTH] ? MAX_VAL : sum_ext[TIME_WIDTH-1:0];
      else if (dec_en)
         time_d = dec_val;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock) begin
      if (resetApp)
         time_q <= INIT_VAL;
      else
         time_q <= time_d;
   end

   assign time_o      = time_q;
   assign will_zero_o = (time_q == TIME_WIDTH'(1));

endmodule

// File: rtl/chess_turn_controller.sv
// Turn and game-clock scheduler: owns the active player, grants moves to the layout
// matrix, runs both countdown clocks and declares the timeout loser.
module chess_turn_controller
   import chess_pkg::*;
#(
   parameter int TIME_WIDTH        = 12,
   parameter int INIT_SECONDS      = 300,
   parameter int INCREMENT_SECONDS = 2,
   parameter int COUNT_WIDTH       = 8
) (
   input  logic                   clock,
   input  logic                   resetApp,
   input  logic                   Tick,
   input  logic                   Start,
   input  logic                   Pause,
   input  logic                   MoveDone,
   output logic                   Player,
   output logic                   MoveEnable,
   output logic [TIME_WIDTH-1:0]  WhiteTime,
   output logic [TIME_WIDTH-1:0]  BlackTime,
   output logic [COUNT_WIDTH-1:0] MoveCount,
   output logic                   GameOver,
   output logic                   Loser
);

   state_e                 state_q;
   logic                   player_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   move_enable_q;
   logic                   game_over_q;
   logic                   loser_q;

   logic run_active, active_will_zero, timeout, commit, reload;
   logic white_zero, black_zero;
   logic white_dec, black_dec, white_inc, black_inc;

   // Pause outranks Tick and MoveDone; a timeout outranks a same-cycle move.
   always_comb begin
      run_active       = (state_q == ST_RUN) && !Pause;
      active_will_zero = (player_q == WHITE_PLAYER) ? white_zero : black_zero;
      timeout          = run_active && Tick && active_will_zero;
      commit           = run_active && MoveDone && !timeout;
      reload           = (state_q == ST_OVER) && Start;
      white_dec        = run_active && Tick && (player_q == WHITE_PLAYER);
      black_dec        = run_active && Tick && (player_q == BLACK_PLAYER);
      white_inc        = commit && (player_q == WHITE_PLAYER);
      black_inc        = commit && (player_q == BLACK_PLAYER);
   end

   player_timer #(
      .TIME_WIDTH       (TIME_WIDTH),
      .INIT_SECONDS     (INIT_SECONDS),
      .INCREMENT_SECONDS(INCREMENT_SECONDS)
   ) u_white_timer (
      .clock      (clock),
      .resetApp   (resetApp),
      .load       (reload),
      .dec_en     (white_dec),
      .inc_en     (white_inc),
      .time_o     (WhiteTime),
      .will_zero_o(white_zero)
   );

   player_timer #(
      .TIME_WIDTH       (TIME_WIDTH),
      .INIT_SECONDS     (INIT_SECONDS),
      .INCREMENT_SECONDS(INCREMENT_SECONDS)
   ) u_black_timer (
      .clock      (clock),
      .resetApp   (resetApp),
      .load       (reload),
      .dec_en     (black_dec),
      .inc_en     (black_inc),
      .time_o     (BlackTime),
      .will_zero_o(black_zero)
   );

   // Outputs are set alongside each state transition so they are registered with it.
   always_ff @(posedge clock) begin
      if (resetApp) begin
         state_q       <= ST_IDLE;
         player_q      <= WHITE_PLAYER;
         count_q       <= '0;
         move_enable_q <= 1'b0;
         game_over_q   <= 1'b0;
         loser_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Start) begin
                  state_q       <= ST_RUN;
                  move_enable_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (Pause) begin
                  state_q       <= ST_PAUSED;
                  move_enable_q <= 1'b0;
               end else if (timeout) begin
                  state_q       <= ST_OVER;
                  move_enable_q <= 1'b0;
                  game_over_q   <= 1'b1;
                  loser_q       <= player_q;
               end else if (commit) begin
                  player_q <= ~player_q;
                  count_q  <= count_q + 1'b1;
               end
            end
            ST_PAUSED: begin
               if (!Pause) begin
                  state_q       <= ST_RUN;
                  move_enable_q <= 1'b1;
               end
            end
            ST_OVER: begin
               if (Start) begin
                  state_q     <= ST_IDLE;
                  player_q    <= WHITE_PLAYER;
                  count_q     <= '0;
                  game_over_q <= 1'b0;
                  loser_q     <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign Player     = player_q;
   assign MoveEnable = move_enable_q;
   assign MoveCount  = count_q;
   assign GameOver   = game_over_q;
   assign Loser      = loser_q;

endmodule

// File: tb/tb_chess_turn_controller.sv
// Scoreboard bench for chess_turn_controller: a rule-level game model predicts every
// cycle's outputs; a separate monitor compares them one edge later.
module tb_chess_turn_controller;

   localparam int TW   = 4;
   localparam int INIT = 5;
   localparam int INC  = 2;
   localparam int CW   = 8;
   localparam int TMAX = (1 << TW) - 1;

   typedef struct packed {
      logic          player;
      logic          move_enable;
      logic          game_over;
      logic          loser;
      logic [TW-1:0] white_time;
      logic [TW-1:0] black_time;
      logic [CW-1:0] move_count;
   } exp_t;

   logic          clock = 1'b0;
   logic          resetApp = 1'b1;
   logic          Tick = 1'b0, Start = 1'b0, Pause = 1'b0, MoveDone = 1'b0;
   logic          Player, MoveEnable, GameOver, Loser;
   logic [TW-1:0] WhiteTime, BlackTime;
   logic [CW-1:0] MoveCount;

   int n_compared   = 0;
   int n_mismatched = 0;
   exp_t exp_q[$];

   chess_turn_controller #(
      .TIME_WIDTH       (TW),
      .INIT_SECONDS     (INIT),
      .INCREMENT_SECONDS(INC),
      .COUNT_WIDTH      (CW)
   ) dut (
      .clock     (clock),
      .resetApp  (resetApp),
      .Tick      (Tick),
      .Start     (Start),
      .Pause     (Pause),
      .MoveDone  (MoveDone),
      .Player    (Player),
      .MoveEnable(MoveEnable),
      .WhiteTime (WhiteTime),
      .BlackTime (BlackTime),
      .MoveCount (MoveCount),
      .GameOver  (GameOver),
      .Loser     (Loser)
   );

   always #5 clock = ~clock;

   // Reference model: game phase as a string, clocks as plain integers.
   string m_phase  = "idle";
   int    m_white  = INIT;
   int    m_black  = INIT;
   bit    m_player = 1'b1;
   int    m_moves  = 0;
   bit    m_loser  = 1'b0;

   function automatic int sat_add(int t);
      return (t + INC > TMAX) ? TMAX : t + INC;
   endfunction

   task automatic model_step(bit rst, bit tick, bit start, bit pause, bit move);
      int t;
      bit timed_out;
      if (rst) begin
         m_phase = "idle"; m_white = INIT; m_black = INIT;
         m_player = 1'b1; m_moves = 0; m_loser = 1'b0;
         return;
      end
      case (m_phase)
         "idle":   if (start) m_phase = "run";
         "paused": if (!pause) m_phase = "run";
         "over":   if (start) begin
            m_phase = "idle"; m_white = INIT; m_black = INIT;
            m_player = 1'b1; m_moves = 0; m_loser = 1'b0;
         end
         "run": begin
            if (pause) m_phase = "paused";
            else begin
               t = m_player ? m_white : m_black;
               timed_out = 1'b0;
               if (tick) begin
                  t = t - 1;
                  if (t == 0) timed_out = 1'b1;
               end
               if (timed_out) begin
                  m_phase = "over";
                  m_loser = m_player;
               end else if (move) begin
                  t = sat_add(t);
               end
               if (m_player) m_white = t; else m_black = t;
               if (!timed_out && move) begin
                  m_player = ~m_player;
                  m_moves  = (m_moves + 1) % (1 << CW);
               end
            end
         end
         default: m_phase = "idle";
      endcase
   endtask

   function automatic exp_t model_outputs();
      exp_t e;
      e.player      = m_player;
      e.move_enable = (m_phase == "run");
      e.game_over   = (m_phase == "over");
      e.loser       = m_loser;
      e.white_time  = TW'(m_white);
      e.black_time  = TW'(m_black);
      e.move_count  = CW'(m_moves);
      return e;
   endfunction

   // Drive one cycle of inputs away from the active edge and queue the prediction.
   task automatic cycle(bit rst, bit tick, bit start, bit pause, bit move);
      @(negedge clock);
      resetApp = rst; Tick = tick; Start = start; Pause = pause; MoveDone = move;
      model_step(rst, tick, start, pause, move);
      exp_q.push_back(model_outputs());
   endtask

   task automatic settle();
      @(posedge clock);
      #1;
   endtask

   task automatic check(string name, int actual, int expected);
      n_compared++;
      if (actual != expected) begin
         n_mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: one prediction per clock edge, compared just after the edge.
   always @(posedge clock) begin
      exp_t e, a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = '{Player, MoveEnable, GameOver, Loser, WhiteTime, BlackTime, MoveCount};
         n_compared++;
         if (a !== e) begin
            n_mismatched++;
            $display("FAIL scoreboard @%0t: got P=%0d ME=%0d GO=%0d L=%0d W=%0d B=%0d MC=%0d expected P=%0d ME=%0d GO=%0d L=%0d W=%0d B=%0d MC=%0d",
                     $time, a.player, a.move_enable, a.game_over, a.loser, a.white_time,
                     a.black_time, a.move_count, e.player, e.move_enable, e.game_over,
                     e.loser, e.white_time, e.black_time, e.move_count);
         end
      end
   end

   initial begin
      bit pause_lvl;
      int budget;

      // Reset, Start, three ticks.
      cycle(1, 0, 0, 0, 0);
      settle();
      check("reset_white", WhiteTime, INIT);
      check("reset_player", Player, 1);
      check("reset_enable", MoveEnable, 0);
      cycle(0, 0, 1, 0, 0);
      repeat (3) cycle(0, 1, 0, 0, 0);
      settle();
      check("s1_white", WhiteTime, 2);
      check("s1_black", BlackTime, 5);
      check("s1_enable", MoveEnable, 1);

      // Tick then move, then black ticks twice.
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      settle();
      check("s2_white", WhiteTime, 6);
      check("s2_player", Player, 0);
      check("s2_count", MoveCount, 1);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      settle();
      check("s2_black", BlackTime, 3);

      // Timeout beats a same-cycle move.
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      repeat (4) cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 1);
      settle();
      check("s3_white", WhiteTime, 0);
      check("s3_gameover", GameOver, 1);
      check("s3_loser", Loser, 1);
      check("s3_player", Player, 1);
      check("s3_count", MoveCount, 0);
      cycle(0, 0, 1, 0, 0);
      settle();
      check("s6_rearm_white", WhiteTime, 5);
      check("s6_rearm_black", BlackTime, 5);
      check("s6_rearm_loser", Loser, 0);
      check("s6_rearm_gameover", GameOver, 0);

      // Moves only: both clocks climb and clamp at the maximum.
      cycle(0, 0, 1, 0, 0);
      repeat (8) cycle(0, 0, 0, 0, 1);
      settle();
      check("s4_white", WhiteTime, 13);
      check("s4_count", MoveCount, 8);
      repeat (4) cycle(0, 0, 0, 0, 1);
      settle();
      check("s4_white_clamp", WhiteTime, 15);
      check("s4_black_clamp", BlackTime, 15);

      // Pause drops ticks and moves.
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 1, 0, 1, 1);
      repeat (3) cycle(0, 1, 0, 1, 0);
      cycle(0, 0, 0, 1, 1);
      settle();
      check("s5_white", WhiteTime, 5);
      check("s5_enable", MoveEnable, 0);
      check("s5_count", MoveCount, 0);
      cycle(0, 0, 0, 0, 0);
      settle();
      check("s5_resume", MoveEnable, 1);

      // Reset mid-run.
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      settle();
      check("s6_mid_white", WhiteTime, 3);
      cycle(1, 1, 0, 0, 1);
      settle();
      check("s6_reset_white", WhiteTime, 5);
      check("s6_reset_enable", MoveEnable, 0);

      // Random play.
      pause_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) pause_lvl = ~pause_lvl;
         cycle($urandom_range(0, 199) == 0,
               $urandom_range(0, 9) < 4,
               $urandom_range(0, 9) == 0,
               pause_lvl,
               $urandom_range(0, 9) < 3);
      end
      cycle(0, 0, 0, 0, 0);

      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         settle();
         budget--;
      end
      if (exp_q.size() > 0) begin
         n_compared++;
         n_mismatched++;
         $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
